// File: rtl/ext_irq_arbiter.sv
// Edge-latching interrupt arbiter: priority level first, round-robin within a level,
// one request at a time toward the core's single external-interrupt port.
`timescale 1ns/1ps
module ext_irq_arbiter #(
    parameter int N_SRC = 16,
    parameter int SRC_W = 4
) (
    input  logic             iCLOCK,
    input  logic             inRESET,
    input  logic             iRESET_SYNC,
    input  logic             iCONF_VALID,
    input  logic [SRC_W-1:0] iCONF_ENTRY,
    input  logic             iCONF_ENABLE,
    input  logic [1:0]       iCONF_LEVEL,
    input  logic [N_SRC-1:0] iIRQ_REQ,
    output logic [N_SRC-1:0] oIRQ_ACK,
    output logic [N_SRC-1:0] oPENDING,
    output logic             oEXT_ACTIVE,
    output logic [5:0]       oEXT_NUM,
    input  logic             iEXT_ACK
);

    localparam logic [1:0] L_IDLE = 2'd0;
    localparam logic [1:0] L_REQ  = 2'd1;
    localparam logic [1:0] L_GAP  = 2'd2;

    logic [1:0]       r_state;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_en;
    logic [1:0]       r_lvl [N_SRC];
    logic [SRC_W-1:0] r_rr;
    logic [SRC_W-1:0] r_grant;
    logic [N_SRC-1:0] r_ack;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_elig;
    logic             w_ack_req;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pend_nxt;
    logic [SRC_W-1:0] w_rr_nxt;
    logic [1:0]       w_maxlvl;
    logic [SRC_W-1:0] w_win;
    int               w_best;
    int               w_dist;

    assign w_rise     = iIRQ_REQ & ~r_prev;
    assign w_elig     = r_pend & r_en;
    assign w_ack_req  = (r_state == L_REQ) && iEXT_ACK;
    // A new edge in the acknowledge cycle re-arms the source instead of being lost.
    assign w_pend_nxt = (r_pend & ~w_clr) | (w_rise & r_en);
    assign w_rr_nxt   = (int'(r_grant) == N_SRC - 1) ? '0 : r_grant + SRC_W'(1);

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_ack_req && int'(r_grant) == i) w_clr[i] = 1'b1;
        end
    end

    // Winner = eligible source at the top level with the smallest upward distance from r_rr.
    always_comb begin
        w_maxlvl = 2'd0;
        w_win    = '0;
        w_best   = N_SRC;
        w_dist   = 0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_elig[i] && r_lvl[i] > w_maxlvl) w_maxlvl = r_lvl[i];
        end
        for (int i = 0; i < N_SRC; i++) begin
            w_dist = (i >= int'(r_rr)) ? i - int'(r_rr) : i + N_SRC - int'(r_rr);
            if (w_elig[i] && r_lvl[i] == w_maxlvl && w_dist < w_best) begin
                w_best = w_dist;
                w_win  = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= L_IDLE;
            r_prev  <= '0;
            r_pend  <= '0;
            r_rr    <= '0;
            r_grant <= '0;
            r_ack   <= '0;
        end else if (iRESET_SYNC) begin
            r_state <= L_IDLE;
            r_prev  <= '0;
            r_pend  <= '0;
            r_rr    <= '0;
            r_grant <= '0;
            r_ack   <= '0;
        end else begin
            r_prev <= iIRQ_REQ;
            r_pend <= w_pend_nxt;
            r_ack  <= w_clr;
            case (r_state)
                L_IDLE: begin
                    if (|w_elig) begin
                        r_grant <= w_win;
                        r_state <= L_REQ;
                    end
                end
                L_REQ: begin
                    if (iEXT_ACK) begin
                        r_rr    <= w_rr_nxt;
                        r_state <= L_GAP;
                    end
                end
                L_GAP:   r_state <= L_IDLE;
                default: r_state <= L_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_en <= '1;
            for (int i = 0; i < N_SRC; i++) r_lvl[i] <= 2'd0;
        end else if (iRESET_SYNC) begin
            r_en <= '1;
            for (int i = 0; i < N_SRC; i++) r_lvl[i] <= 2'd0;
        end else begin
            // Entries beyond N_SRC never match, so out-of-range writes fall away.
            for (int i = 0; i < N_SRC; i++) begin
                if (iCONF_VALID && int'(iCONF_ENTRY) == i) begin
                    r_en[i]  <= iCONF_ENABLE;
                    r_lvl[i] <= iCONF_LEVEL;
                end
            end
        end
    end

    assign oIRQ_ACK    = r_ack;
    assign oPENDING    = r_pend;
    assign oEXT_ACTIVE = (r_state == L_REQ);
    assign oEXT_NUM    = 6'(r_grant);

endmodule
